// File: rtl/perf_counter_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : perf_counter_bank_pkg
// Description : Shared types and register offsets for the perf counter bank.
// Revision    : 1.0 - initial release
// ============================================================================
package perf_counter_bank_pkg;

    localparam int PERF_NUM_EVENTS = 16;

    typedef logic [$clog2(PERF_NUM_EVENTS)-1:0] perf_event_idx_t;

    // Byte offsets of the registers inside one 16-byte counter window
    localparam logic [3:0] PERF_REG_EVENT_SEL = 4'h0;
    localparam logic [3:0] PERF_REG_CTRL      = 4'h4;
    localparam logic [3:0] PERF_REG_COUNT_LO  = 4'h8;
    localparam logic [3:0] PERF_REG_COUNT_HI  = 4'hC;

    localparam logic [3:0] PERF_REG_GLOBAL_CTRL = 4'h0;
    localparam logic [3:0] PERF_REG_OVF_STATUS  = 4'h4;

    typedef struct packed {
        logic irq_en;
        logic enable;
    } perf_ctrl_t;

endpackage : perf_counter_bank_pkg
`default_nettype wire

// File: rtl/perf_counter_bank_slice.sv
`default_nettype none
// ============================================================================
// Module      : perf_counter_slice
// Description : One programmable event counter with write/increment priority
//               and wrap detection.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_counter_slice
    import perf_counter_bank_pkg::*;
#(
    parameter int NUM_EVENTS    = 16,
    parameter int COUNTER_WIDTH = 48,
    parameter int EW            = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     global_enable,
    input  logic [NUM_EVENTS-1:0]    perf_events,
    input  logic                     clear,
    input  logic                     sel_we,
    input  logic                     ctrl_we,
    input  logic                     lo_we,
    input  logic                     hi_we,
    input  logic [EW-1:0]            wdata_sel,
    input  perf_ctrl_t               wdata_ctrl,
    input  logic [31:0]              wdata_lo,
    input  logic [COUNTER_WIDTH-33:0] wdata_hi,
    output logic [EW-1:0]            event_sel,
    output perf_ctrl_t               ctrl,
    output logic [COUNTER_WIDTH-1:0] count,
    output logic                     wrap
);

    logic [EW-1:0]            event_sel_q, event_sel_d;
    perf_ctrl_t               ctrl_q, ctrl_d;
    logic [COUNTER_WIDTH-1:0] count_q, count_d;
    logic                     inc_w;
    logic                     cpu_wins_w;

    assign inc_w      = global_enable & ctrl_q.enable & perf_events[event_sel_q];
    assign cpu_wins_w = clear | lo_we | hi_we;

    always_comb begin
        event_sel_d = sel_we  ? wdata_sel  : event_sel_q;
        ctrl_d      = ctrl_we ? wdata_ctrl : ctrl_q;
        count_d     = count_q;
        // Software writes and the global clear drop a coincident increment
        if (clear) begin
            count_d = '0;
        end else if (lo_we) begin
            count_d[31:0] = wdata_lo;
        end else if (hi_we) begin
            count_d[COUNTER_WIDTH-1:32] = wdata_hi;
        end else if (inc_w) begin
            count_d = count_q + {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            event_sel_q <= '0;
            ctrl_q      <= '0;
            count_q     <= '0;
        end else begin
            event_sel_q <= event_sel_d;
            ctrl_q      <= ctrl_d;
            count_q     <= count_d;
        end
    end

    assign event_sel = event_sel_q;
    assign ctrl      = ctrl_q;
    assign count     = count_q;
    assign wrap      = inc_w & ~cpu_wins_w & (&count_q);

endmodule : perf_counter_slice
`default_nettype wire

// File: rtl/perf_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : perf_counter_bank
// Description : I/O-bus slave holding a bank of programmable event counters
//               with sticky overflow status and a level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_counter_bank
    import perf_counter_bank_pkg::*;
#(
    parameter int          NUM_EVENTS    = 16,
    parameter int          NUM_COUNTERS  = 4,
    parameter int          COUNTER_WIDTH = 48,
    parameter logic [31:0] BASE_ADDRESS  = 32'hffff0200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  io_write_en,
    input  logic                  io_read_en,
    input  logic [31:0]           io_address,
    input  logic [31:0]           io_write_data,
    output logic [31:0]           io_read_data,
    input  logic [NUM_EVENTS-1:0] perf_events,
    output logic                  overflow_interrupt
);

    localparam int          EW         = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
    localparam logic [31:0] GLOBAL_IDX = 32'(NUM_COUNTERS);

    logic [31:0] offset_w, idx_w;
    logic [3:0]  reg_w;
    logic        aligned_w;

    logic [EW-1:0]            event_sel_w [NUM_COUNTERS];
    perf_ctrl_t               ctrl_w      [NUM_COUNTERS];
    logic [COUNTER_WIDTH-1:0] count_w     [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0]  wrap_w, irq_en_w;
    logic [NUM_COUNTERS-1:0]  sel_we_w, ctrl_we_w, lo_we_w, hi_we_w;
    logic                     global_we_w, ovf_we_w, clear_all_w;

    logic [31:0]             rd_data_w, hi_capture_w;
    logic                    hi_capture_en_w;
    logic [31:0]             io_read_data_q, io_read_data_d;
    logic [31:0]             hi_shadow_q, hi_shadow_d;
    logic [NUM_COUNTERS-1:0] ovf_status_q, ovf_status_d, ovf_clr_w;
    logic                    global_enable_q, global_enable_d;
    logic                    overflow_interrupt_q, overflow_interrupt_d;

    assign offset_w  = io_address - BASE_ADDRESS;
    assign idx_w     = offset_w >> 4;
    assign reg_w     = offset_w[3:0];
    assign aligned_w = (offset_w[1:0] == 2'b00);

    generate
        for (genvar n = 0; n < NUM_COUNTERS; n++) begin : g_slice
            perf_counter_slice #(
                .NUM_EVENTS    (NUM_EVENTS),
                .COUNTER_WIDTH (COUNTER_WIDTH),
                .EW            (EW)
            ) u_slice (
                .clk           (clk),
                .reset         (reset),
                .global_enable (global_enable_q),
                .perf_events   (perf_events),
                .clear         (clear_all_w),
                .sel_we        (sel_we_w[n]),
                .ctrl_we       (ctrl_we_w[n]),
                .lo_we         (lo_we_w[n]),
                .hi_we         (hi_we_w[n]),
                .wdata_sel     (io_write_data[EW-1:0]),
                .wdata_ctrl    (perf_ctrl_t'(io_write_data[1:0])),
                .wdata_lo      (io_write_data),
                .wdata_hi      (io_write_data[COUNTER_WIDTH-33:0]),
                .event_sel     (event_sel_w[n]),
                .ctrl          (ctrl_w[n]),
                .count         (count_w[n]),
                .wrap          (wrap_w[n])
            );
            assign irq_en_w[n] = ctrl_w[n].irq_en;
        end
    endgenerate

    always_comb begin
        sel_we_w    = '0;
        ctrl_we_w   = '0;
        lo_we_w     = '0;
        hi_we_w     = '0;
        global_we_w = 1'b0;
        ovf_we_w    = 1'b0;
        if (io_write_en && aligned_w) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                if (idx_w == 32'(i)) begin
                    sel_we_w[i]  = (reg_w == PERF_REG_EVENT_SEL);
                    ctrl_we_w[i] = (reg_w == PERF_REG_CTRL);
                    lo_we_w[i]   = (reg_w == PERF_REG_COUNT_LO);
                    hi_we_w[i]   = (reg_w == PERF_REG_COUNT_HI);
                end
            end
            if (idx_w == GLOBAL_IDX) begin
                global_we_w = (reg_w == PERF_REG_GLOBAL_CTRL);
                ovf_we_w    = (reg_w == PERF_REG_OVF_STATUS);
            end
        end
    end

    always_comb begin
        rd_data_w       = '0;
        hi_capture_w    = '0;
        hi_capture_en_w = 1'b0;
        if (aligned_w) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                if (idx_w == 32'(i)) begin
                    case (reg_w)
                        PERF_REG_EVENT_SEL: rd_data_w = 32'(event_sel_w[i]);
                        PERF_REG_CTRL:      rd_data_w = 32'(ctrl_w[i]);
                        PERF_REG_COUNT_LO: begin
                            rd_data_w       = count_w[i][31:0];
                            hi_capture_w    = 32'(count_w[i][COUNTER_WIDTH-1:32]);
                            hi_capture_en_w = 1'b1;
                        end
                        PERF_REG_COUNT_HI:  rd_data_w = hi_shadow_q;
                        default:            rd_data_w = '0;
                    endcase
                end
            end
            if (idx_w == GLOBAL_IDX) begin
                case (reg_w)
                    PERF_REG_GLOBAL_CTRL: rd_data_w = {31'b0, global_enable_q};
                    PERF_REG_OVF_STATUS:  rd_data_w = 32'(ovf_status_q);
                    default:              rd_data_w = '0;
                endcase
            end
        end
    end

    always_comb begin
        io_read_data_d  = io_read_en ? rd_data_w : io_read_data_q;
        hi_shadow_d     = (io_read_en && hi_capture_en_w) ? hi_capture_w : hi_shadow_q;
        global_enable_d = global_we_w ? io_write_data[0] : global_enable_q;
        clear_all_w     = global_we_w & io_write_data[1];
        ovf_clr_w       = ovf_we_w ? io_write_data[NUM_COUNTERS-1:0] : '0;
        // A new wrap outranks a same-cycle write-1-to-clear
        ovf_status_d    = (ovf_status_q & ~ovf_clr_w) | wrap_w;
        overflow_interrupt_d = |(ovf_status_q & irq_en_w);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            io_read_data_q       <= '0;
            hi_shadow_q          <= '0;
            global_enable_q      <= 1'b0;
            ovf_status_q         <= '0;
            overflow_interrupt_q <= 1'b0;
        end else begin
            io_read_data_q       <= io_read_data_d;
            hi_shadow_q          <= hi_shadow_d;
            global_enable_q      <= global_enable_d;
            ovf_status_q         <= ovf_status_d;
            overflow_interrupt_q <= overflow_interrupt_d;
        end
    end

    assign io_read_data       = io_read_data_q;
    assign overflow_interrupt = overflow_interrupt_q;

endmodule : perf_counter_bank
`default_nettype wire

// File: tb/tb_perf_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_perf_counter_bank
// Description : Directed self-checking bench for perf_counter_bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_perf_counter_bank;

    localparam logic [31:0] BASE = 32'hffff0200;
    localparam logic [31:0] GCTL = BASE + 32'h40;
    localparam logic [31:0] OVF  = BASE + 32'h44;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        io_write_en = 1'b0;
    logic        io_read_en = 1'b0;
    logic [31:0] io_address = '0;
    logic [31:0] io_write_data = '0;
    logic [31:0] io_read_data;
    logic [15:0] perf_events = '0;
    logic        overflow_interrupt;

    int checks = 0;
    int errors = 0;
    logic [31:0] rdata;

    perf_counter_bank #(
        .NUM_EVENTS    (16),
        .NUM_COUNTERS  (4),
        .COUNTER_WIDTH (48),
        .BASE_ADDRESS  (BASE)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .io_write_en        (io_write_en),
        .io_read_en         (io_read_en),
        .io_address         (io_address),
        .io_write_data      (io_write_data),
        .io_read_data       (io_read_data),
        .perf_events        (perf_events),
        .overflow_interrupt (overflow_interrupt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] creg(input int n, input int off);
        return BASE + 32'(16 * n + off);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        io_write_en   = 1'b1;
        io_address    = addr;
        io_write_data = data;
        @(negedge clk);
        io_write_en   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        io_read_en = 1'b1;
        io_address = addr;
        @(negedge clk);
        io_read_en = 1'b0;
        data       = io_read_data;
    endtask

    task automatic pulse(input int idx, input int times);
        for (int k = 0; k < times; k++) begin
            @(negedge clk);
            perf_events = 16'(1) << idx;
            @(negedge clk);
            perf_events = '0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a <= 32'h48; a += 4) begin
            rd(BASE + 32'(a), rdata);
            check($sformatf("%s@%0h", tag, a), 64'(rdata), 64'h0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_irq", 64'(overflow_interrupt), 64'h0);
        check("reset_rdata", 64'(io_read_data), 64'h0);
        reset = 1'b1;
        check_all_zero("reset_regs");

        // basic counting on counter 0, event 3
        wr(creg(0, 0), 32'd3);
        wr(creg(0, 4), 32'd1);
        wr(GCTL, 32'd1);
        pulse(3, 10);
        pulse(2, 5);
        rd(creg(0, 0), rdata);  check("c0_sel", 64'(rdata), 64'd3);
        rd(creg(0, 4), rdata);  check("c0_ctrl", 64'(rdata), 64'd1);
        rd(creg(0, 8), rdata);  check("c0_lo", 64'(rdata), 64'd10);
        rd(creg(0, 12), rdata); check("c0_hi", 64'(rdata), 64'd0);
        rd(creg(1, 8), rdata);  check("c1_lo", 64'(rdata), 64'd0);

        // full-width wrap with interrupt
        wr(creg(0, 4), 32'd3);
        wr(creg(0, 8), 32'hffffffff);
        wr(creg(0, 12), 32'h0000ffff);
        pulse(3, 1);
        check("irq_lag", 64'(overflow_interrupt), 64'h0);
        @(negedge clk);
        check("irq_rise", 64'(overflow_interrupt), 64'h1);
        rd(creg(0, 8), rdata);  check("wrap_lo", 64'(rdata), 64'h0);
        rd(creg(0, 12), rdata); check("wrap_hi", 64'(rdata), 64'h0);
        rd(OVF, rdata);         check("ovf_set", 64'(rdata), 64'h1);
        wr(OVF, 32'd1);
        @(negedge clk);
        check("irq_drop", 64'(overflow_interrupt), 64'h0);
        rd(OVF, rdata);         check("ovf_clr", 64'(rdata), 64'h0);

        // hi shadow holds the value seen at the LO read
        wr(creg(0, 8), 32'hffffffff);
        wr(creg(0, 12), 32'h1);
        rd(creg(0, 8), rdata);  check("shadow_lo", 64'(rdata), 64'hffffffff);
        pulse(3, 1);
        rd(creg(0, 12), rdata); check("shadow_hi", 64'(rdata), 64'h1);
        rd(creg(0, 8), rdata);  check("carry_lo", 64'(rdata), 64'h0);
        rd(creg(0, 12), rdata); check("carry_hi", 64'(rdata), 64'h2);

        // LO write beats a coincident event
        @(negedge clk);
        io_write_en = 1'b1; io_address = creg(0, 8); io_write_data = 32'd100;
        perf_events = 16'h0008;
        @(negedge clk);
        io_write_en = 1'b0; perf_events = '0;
        rd(creg(0, 8), rdata);  check("wr_vs_inc", 64'(rdata), 64'd100);

        // wrap beats a coincident W1C
        wr(creg(0, 8), 32'hffffffff);
        wr(creg(0, 12), 32'h0000ffff);
        @(negedge clk);
        io_write_en = 1'b1; io_address = OVF; io_write_data = 32'd1;
        perf_events = 16'h0008;
        @(negedge clk);
        io_write_en = 1'b0; perf_events = '0;
        rd(OVF, rdata);         check("w1c_vs_wrap", 64'(rdata), 64'h1);
        rd(creg(0, 8), rdata);  check("w1c_wrap_lo", 64'(rdata), 64'h0);
        wr(OVF, 32'd1);

        // global clear
        wr(creg(1, 0), 32'd5);
        wr(creg(1, 4), 32'd1);
        pulse(5, 3);
        pulse(3, 2);
        rd(creg(1, 8), rdata);  check("c1_pre", 64'(rdata), 64'd3);
        rd(creg(0, 8), rdata);  check("c0_pre", 64'(rdata), 64'd2);
        wr(GCTL, 32'd3);
        rd(creg(0, 8), rdata);  check("gclr_c0", 64'(rdata), 64'd0);
        rd(creg(1, 8), rdata);  check("gclr_c1", 64'(rdata), 64'd0);
        rd(GCTL, rdata);        check("gclr_gen", 64'(rdata), 64'd1);
        rd(creg(1, 0), rdata);  check("gclr_sel", 64'(rdata), 64'd5);
        rd(BASE + 32'h50, rdata); check("unmapped", 64'(rdata), 64'd0);

        // reset between LO and HI reads
        pulse(5, 4);
        wr(creg(1, 12), 32'd7);
        rd(creg(1, 8), rdata);  check("pre_rst_lo", 64'(rdata), 64'd4);
        @(negedge clk);
        io_read_en = 1'b1; io_address = creg(1, 12); reset = 1'b0;
        @(negedge clk);
        io_read_en = 1'b0; reset = 1'b1;
        check("rst_pending_rd", 64'(io_read_data), 64'h0);
        check("rst_irq", 64'(overflow_interrupt), 64'h0);
        check_all_zero("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_perf_counter_bank
`default_nettype wire
